alkcflg: RTL and testbench

ALKCFLG -- requirements
Module: alkcflg

---
 rtl/alk_pkg.sv | 17 +
 rtl/alkdivcnt.sv | 27 ++
 rtl/alkcflg.sv | 101 ++++++++++
 tb/tb_alkcflg.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alk_pkg.sv
// Shared definitions for the ALKC carry flag / divide sequencer.
package alk_pkg;

    // One quotient bit per step of a non-restoring divide.
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    // Counter load value: counts DIV_STEPS-1 down to 0, one DIV cycle per value.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        FIXUP = 2'd2
    } alk_state_e;

endpackage

// File: rtl/alkdivcnt.sv
// Remaining-step counter for the divide: loadable, decrementing, holding,
// with asynchronous reset and a synchronous clear.
module alkdivcnt
    import alk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Clear beats load beats decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
    end

endmodule

// File: rtl/alkcflg.sv
// ALKC microarchitectural carry flag and divide-step sequencer.
// IDLE: ALKC may be loaded from the ALU carry. A divide start runs 32 DIV
// cycles (ALKC tracks the carry, carry-invert follows the quotient bit rule),
// then a single FIXUP cycle before returning to IDLE.
module alkcflg
    import alk_pkg::*;
(
    input  logic             clk,
    input  logic             reset_h,
    input  logic             stall_l,
    input  logic             alu_cout_h,
    input  logic             alkc_load_h,
    input  logic             alkc_clear_h,
    input  logic             div_start_h,
    input  logic             div_sign_h,
    output logic             alkc_flag_h,
    output logic             carry_invert_h,
    output logic             alpctl_divdbl_l,
    output logic             div_busy_h,
    output logic             div_last_h,
    output logic [CNT_W-1:0] div_count_h
);

    alk_state_e state, state_nxt;
    logic       alkc_nxt, ci_nxt;
    logic       cnt_clr, cnt_ld, cnt_dec;

    alkdivcnt u_cnt (
        .clk    (clk),
        .rst    (reset_h),
        .clr    (cnt_clr),
        .ld     (cnt_ld),
        .ld_val (CNT_LOAD),
        .dec    (cnt_dec),
        .cnt    (div_count_h)
    );

    // State, ALKC and carry-invert registers.
    always_ff @(posedge clk or posedge reset_h) begin
        if (reset_h) begin
            state          <= IDLE;
            alkc_flag_h    <= 1'b0;
            carry_invert_h <= 1'b0;
        end else begin
            state          <= state_nxt;
            alkc_flag_h    <= alkc_nxt;
            carry_invert_h <= ci_nxt;
        end
    end

    // Next state and flag values; a stall leaves every default (hold) in place.
    always_comb begin
        state_nxt = state;
        alkc_nxt  = alkc_flag_h;
        ci_nxt    = carry_invert_h;
        cnt_clr   = 1'b0;
        cnt_ld    = 1'b0;
        cnt_dec   = 1'b0;
        if (stall_l) begin
            if (alkc_clear_h) begin
                // Clear aborts any divide and wins over start/load.
                state_nxt = IDLE;
                alkc_nxt  = 1'b0;
                ci_nxt    = 1'b0;
                cnt_clr   = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (div_start_h) begin
                            state_nxt = DIV;
                            ci_nxt    = 1'b1;
                            cnt_ld    = 1'b1;
                        end else if (alkc_load_h) begin
                            alkc_nxt = alu_cout_h;
                        end
                    end
                    DIV: begin
                        alkc_nxt = alu_cout_h;
                        ci_nxt   = ~(alu_cout_h ^ div_sign_h);
                        if (div_count_h == '0)
                            state_nxt = FIXUP;
                        else
                            cnt_dec = 1'b1;
                    end
                    FIXUP: begin
                        alkc_nxt  = alu_cout_h;
                        ci_nxt    = 1'b0;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Status outputs decode from state alone.
    assign div_busy_h      = (state != IDLE);
    assign div_last_h      = (state == FIXUP);
    assign alpctl_divdbl_l = (state != DIV);

endmodule

// File: tb/tb_alkcflg.sv
// Self-checking bench for alkcflg: vector table plus multi-cycle sequences,
// expectations queued at drive time and compared after the clock edge.
module tb_alkcflg;

    logic       clk = 1'b0;
    logic       reset_h, stall_l, alu_cout_h, alkc_load_h, alkc_clear_h;
    logic       div_start_h, div_sign_h;
    logic       alkc_flag_h, carry_invert_h, alpctl_divdbl_l;
    logic       div_busy_h, div_last_h;
    logic [4:0] div_count_h;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       start, load, clear, stall_l, cout, sign;
        logic       alkc, ci, divdbl_l, busy, last;
        logic [4:0] cnt;
    } vec_t;

    vec_t exp_q[$];

    alkcflg dut (
        .clk             (clk),
        .reset_h         (reset_h),
        .stall_l         (stall_l),
        .alu_cout_h      (alu_cout_h),
        .alkc_load_h     (alkc_load_h),
        .alkc_clear_h    (alkc_clear_h),
        .div_start_h     (div_start_h),
        .div_sign_h      (div_sign_h),
        .alkc_flag_h     (alkc_flag_h),
        .carry_invert_h  (carry_invert_h),
        .alpctl_divdbl_l (alpctl_divdbl_l),
        .div_busy_h      (div_busy_h),
        .div_last_h      (div_last_h),
        .div_count_h     (div_count_h)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, ld, cl, sl, co, sg,
                                input logic ak, ci, dd, bz, la, input logic [4:0] cn);
        vec_t v;
        v.start = st; v.load = ld; v.clear = cl; v.stall_l = sl; v.cout = co; v.sign = sg;
        v.alkc = ak; v.ci = ci; v.divdbl_l = dd; v.busy = bz; v.last = la; v.cnt = cn;
        return v;
    endfunction

    task automatic check(input vec_t e, input string name);
        checks++;
        if (alkc_flag_h !== e.alkc || carry_invert_h !== e.ci || alpctl_divdbl_l !== e.divdbl_l ||
            div_busy_h !== e.busy || div_last_h !== e.last || div_count_h !== e.cnt) begin
            failures++;
            $display("FAIL %s t=%0t got alkc=%b ci=%b divdbl_l=%b busy=%b last=%b cnt=%0d exp alkc=%b ci=%b divdbl_l=%b busy=%b last=%b cnt=%0d",
                     name, $time, alkc_flag_h, carry_invert_h, alpctl_divdbl_l, div_busy_h,
                     div_last_h, div_count_h, e.alkc, e.ci, e.divdbl_l, e.busy, e.last, e.cnt);
        end
    endtask

    // Drive one cycle, queue its expectation, compare just after the edge.
    task automatic step(input vec_t v, input string name);
        vec_t e;
        div_start_h  = v.start;
        alkc_load_h  = v.load;
        alkc_clear_h = v.clear;
        stall_l      = v.stall_l;
        alu_cout_h   = v.cout;
        div_sign_h   = v.sign;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(e, name);
    endtask

    // Full divide from IDLE. toggle: carry pattern 1,0,1,0.. else constant 1.
    // Optional stall of stall_len cycles inserted before DIV step stall_at.
    task automatic divide(input bit toggle, input bit sign, input int stall_at,
                          input int stall_len, input logic alkc0, input string name);
        vec_t v;
        logic c, ci, last_c, last_ci;
        v = mk(1,0,0,1,0,sign, alkc0,1,0,1,0, 5'd31);
        step(v, {name, "_start"});
        last_c  = alkc0;
        last_ci = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    v = mk(1,1,0,0,~last_c,sign, last_c,last_ci,0,1,0, 5'(32 - k));
                    step(v, {name, "_stall"});
                end
            end
            c  = toggle ? ((k % 2) == 1) : 1'b1;
            ci = ~(c ^ sign);
            if (k < 32)
                v = mk(0,0,0,1,c,sign, c,ci,0,1,0, 5'(31 - k));
            else
                v = mk(0,0,0,1,c,sign, c,ci,1,1,1, 5'd0);
            step(v, (k < 32) ? {name, "_div"} : {name, "_enter_fixup"});
            last_c  = c;
            last_ci = ci;
        end
        v = mk(0,0,0,1,0,sign, 0,0,1,0,0, 5'd0);
        step(v, {name, "_fixup_exit"});
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        reset_h = 1'b1; stall_l = 1'b1; alu_cout_h = 1'b0; alkc_load_h = 1'b0;
        alkc_clear_h = 1'b0; div_start_h = 1'b0; div_sign_h = 1'b0;

        // Flag load, hold, clear-over-start, stall, start-over-load, DIV steps, abort.
        tbl[0] = mk(0,1,0,1,1,0, 1,0,1,0,0, 5'd0);
        tbl[1] = mk(0,1,0,1,0,0, 0,0,1,0,0, 5'd0);
        tbl[2] = mk(0,1,0,1,1,0, 1,0,1,0,0, 5'd0);
        tbl[3] = mk(0,0,0,1,0,0, 1,0,1,0,0, 5'd0);
        tbl[4] = mk(1,1,1,1,1,0, 0,0,1,0,0, 5'd0);
        tbl[5] = mk(1,1,0,0,1,0, 0,0,1,0,0, 5'd0);
        tbl[6] = mk(1,1,0,1,1,0, 0,1,0,1,0, 5'd31);
        tbl[7] = mk(0,1,0,1,1,1, 1,1,0,1,0, 5'd30);
        tbl[8] = mk(1,0,0,1,0,1, 0,0,0,1,0, 5'd29);
        tbl[9] = mk(0,0,1,1,1,0, 0,0,1,0,0, 5'd0);

        repeat (2) @(posedge clk);
        #1;
        check(mk(0,0,0,1,0,0, 0,0,1,0,0, 5'd0), "reset_state");
        reset_h = 1'b0;

        for (int i = 0; i < 10; i++)
            step(tbl[i], $sformatf("table_%0d", i));

        divide(1'b0, 1'b0, 0, 0, 1'b0, "div_const");
        divide(1'b1, 1'b1, 0, 0, 1'b0, "div_toggle");
        divide(1'b0, 1'b0, 22, 3, 1'b0, "div_stall");

        // Clear at count 5 with start/load also asserted: back to IDLE, no FIXUP.
        step(mk(1,0,0,1,0,0, 0,1,0,1,0, 5'd31), "clr5_start");
        for (int k = 1; k <= 26; k++)
            step(mk(0,0,0,1,1,0, 1,0,0,1,0, 5'(31 - k)), "clr5_div");
        step(mk(1,1,1,1,1,0, 0,0,1,0,0, 5'd0), "clr5_clear");
        step(mk(0,0,0,1,1,0, 0,0,1,0,0, 5'd0), "clr5_idle");

        // Asynchronous reset mid-divide at count 17.
        step(mk(1,0,0,1,0,0, 0,1,0,1,0, 5'd31), "rst17_start");
        for (int k = 1; k <= 14; k++)
            step(mk(0,0,0,1,1,0, 1,0,0,1,0, 5'(31 - k)), "rst17_div");
        #2;
        reset_h = 1'b1;
        #1;
        check(mk(0,0,0,1,0,0, 0,0,1,0,0, 5'd0), "rst17_async");
        @(posedge clk);
        #1;
        reset_h = 1'b0;
        step(mk(0,0,0,1,1,0, 0,0,1,0,0, 5'd0), "rst17_idle");
        step(mk(0,1,0,1,1,0, 1,0,1,0,0, 5'd0), "rst17_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
